// File: rtl/xil_mem_sp_be_param_pkg.sv
// Shared definitions for the parametrised single-port byte-enable memory:
// read-during-write mode constants, clear-sequencer state type and a clog2 helper.
package xil_mem_sp_be_param_pkg;

  localparam int MEM_READ_FIRST  = 32'sd0;
  localparam int MEM_WRITE_FIRST = 32'sd1;

  typedef enum logic [0:0] {
    CLR_CLEAR = 1'b0,
    CLR_READY = 1'b1
  } clr_state_e;

  // Ceiling log2 of a positive value; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/xil_mem_sp_be_param_if.sv
// Access bus of the single-port byte-enable memory. The master issues accesses,
// the slave (the memory) returns read data, a read-valid pulse and busy.
interface xil_mem_sp_be_param_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADR_BITS   = 9
);

  logic                      i_en;
  logic [DATA_BYTES-1:0]     i_wen;
  logic [ADR_BITS-1:0]       i_adr;
  logic [8*DATA_BYTES-1:0]   i_wdata;
  logic [8*DATA_BYTES-1:0]   o_rdata;
  logic                      o_rvalid;
  logic                      o_busy;

  modport master (
    output i_en, i_wen, i_adr, i_wdata,
    input  o_rdata, o_rvalid, o_busy
  );

  modport slave (
    input  i_en, i_wen, i_adr, i_wdata,
    output o_rdata, o_rvalid, o_busy
  );

endinterface

// File: rtl/xil_mem_sp_be_param_clr_seq.sv
// Post-reset clear sequencer: walks every word address once, one per cycle,
// requesting a zero write, and holds busy high for exactly DEPTH cycles.
// With INIT_CLEAR==0 the sequencer is absent and the block is always ready.
module xil_mem_clr_seq
  import xil_mem_sp_be_param_pkg::*;
#(
  parameter int ADR_BITS   = 9,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                busy,
  output logic                clr_we,
  output logic [ADR_BITS-1:0] clr_adr
);

  if (INIT_CLEAR != 0) begin : g_clear

    clr_state_e          state_r;
    clr_state_e          state_nx;
    logic [ADR_BITS-1:0] cnt_r;
    logic [ADR_BITS-1:0] cnt_nx;
    logic                busy_r;

    // State, address counter and busy flag; reset restarts the walk at word 0.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r <= CLR_CLEAR;
        cnt_r   <= '0;
        busy_r  <= 1'b1;
      end else begin
        state_r <= state_nx;
        cnt_r   <= cnt_nx;
        busy_r  <= (state_nx == CLR_CLEAR);
      end
    end

    // Next state: advance one word per cycle, leave CLEAR after the last word.
    always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      case (state_r)
        CLR_CLEAR: begin
          cnt_nx = cnt_r + {{(ADR_BITS-1){1'b0}}, 1'b1};
          if (cnt_r == {ADR_BITS{1'b1}}) begin
            state_nx = CLR_READY;
          end else begin
            state_nx = CLR_CLEAR;
          end
        end
        CLR_READY: begin
          state_nx = CLR_READY;
        end
        default: begin
          // Unknown encoding: fall back to a full re-clear.
          state_nx = CLR_CLEAR;
          cnt_nx   = '0;
        end
      endcase
    end

    assign busy    = busy_r;
    assign clr_we  = busy_r;
    assign clr_adr = cnt_r;

  end else begin : g_no_clear

    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_adr = '0;

  end

endmodule

// File: rtl/xil_mem_sp_be_param.sv
// Parametrised single-port block RAM with per-byte write enables, selectable
// read-first/write-first behaviour, optional output register and a post-reset
// clear sequence. The storage and read register are coded in the single-port
// byte-write style that XST maps onto block RAM.
module xil_mem_sp_be_param
  import xil_mem_sp_be_param_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int ADR_BITS    = 9,
  parameter int WRITE_FIRST = MEM_READ_FIRST,
  parameter int OUT_REG     = 0,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xil_mem_sp_be_param_if.slave   bus
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int DEPTH = 2 ** ADR_BITS;

  logic                  busy_s;
  logic                  clr_we_s;
  logic [ADR_BITS-1:0]   clr_adr_s;

  logic                  acc_s;
  logic                  port_en_s;
  logic [DATA_BYTES-1:0] port_be_s;
  logic [ADR_BITS-1:0]   port_adr_s;
  logic [DW-1:0]         port_wdata_s;

  logic [DW-1:0]         mem_r [DEPTH];
  logic [DW-1:0]         rd_data_r;
  logic                  rd_valid_r;

  xil_mem_clr_seq #(
    .ADR_BITS   (ADR_BITS),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy_s),
    .clr_we  (clr_we_s),
    .clr_adr (clr_adr_s)
  );

  // Single write port: the clear sequencer owns it while busy, the user otherwise.
  // Reset cycles never write, so reset alone leaves the contents untouched.
  always_comb begin
    acc_s = rst_n & bus.i_en & ~busy_s;
    if (clr_we_s) begin
      port_en_s    = rst_n;
      port_be_s    = '1;
      port_adr_s   = clr_adr_s;
      port_wdata_s = '0;
    end else begin
      port_en_s    = acc_s;
      port_be_s    = bus.i_wen;
      port_adr_s   = bus.i_adr;
      port_wdata_s = bus.i_wdata;
    end
  end

  // Byte-granular write into the storage array.
  always_ff @(posedge clk) begin
    if (port_en_s) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (port_be_s[b]) begin
          mem_r[port_adr_s][8*b +: 8] <= port_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Synchronous read: old bytes in read-first mode, written bytes replace old
  // ones in write-first mode; data holds when there is no access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= acc_s;
      if (acc_s) begin
        for (int b = 0; b < DATA_BYTES; b++) begin
          if ((WRITE_FIRST == MEM_WRITE_FIRST) && bus.i_wen[b]) begin
            rd_data_r[8*b +: 8] <= bus.i_wdata[8*b +: 8];
          end else begin
            rd_data_r[8*b +: 8] <= mem_r[bus.i_adr][8*b +: 8];
          end
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg

    logic [DW-1:0] out_data_r;
    logic          out_valid_r;

    // Output pipeline stage; captures only on a valid read so it holds when idle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_data_r  <= '0;
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= rd_valid_r;
        if (rd_valid_r) begin
          out_data_r <= rd_data_r;
        end
      end
    end

    assign bus.o_rdata  = out_data_r;
    assign bus.o_rvalid = out_valid_r;

  end else begin : g_no_out_reg

    assign bus.o_rdata  = rd_data_r;
    assign bus.o_rvalid = rd_valid_r;

  end

  assign bus.o_busy = busy_s;

endmodule

// File: tb/tb_xil_mem_sp_be_param.sv
// Bench for xil_mem_sp_be_param: two instances (read-first/no output register and
// write-first/output register) driven with identical directed and random
// accesses, compared every cycle against a word-array reference model.
module tb_xil_mem_sp_be_param;

  localparam int DB    = 4;
  localparam int AB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  xil_mem_sp_be_param_if #(.DATA_BYTES(DB), .ADR_BITS(AB)) ifa ();
  xil_mem_sp_be_param_if #(.DATA_BYTES(DB), .ADR_BITS(AB)) ifb ();

  xil_mem_sp_be_param #(
    .DATA_BYTES(DB), .ADR_BITS(AB), .WRITE_FIRST(0), .OUT_REG(0), .INIT_CLEAR(1)
  ) dut_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  xil_mem_sp_be_param #(
    .DATA_BYTES(DB), .ADR_BITS(AB), .WRITE_FIRST(1), .OUT_REG(1), .INIT_CLEAR(1)
  ) dut_wf (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  int          busy_left;
  logic [31:0] a_data, b1_data, b_data;
  logic        a_valid, b1_valid, b_valid;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] wen, input logic [3:0] adr,
                       input logic [31:0] wd);
    ifa.i_en = en;  ifa.i_wen = wen;  ifa.i_adr = adr;  ifa.i_wdata = wd;
    ifb.i_en = en;  ifb.i_wen = wen;  ifb.i_adr = adr;  ifb.i_wdata = wd;
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    logic [31:0] old_w;
    logic [31:0] merged;
    logic        acc;
    @(posedge clk);
    if (!rst_n) begin
      busy_left = DEPTH;
      a_data  = 32'h0;  a_valid  = 1'b0;
      b1_data = 32'h0;  b1_valid = 1'b0;
      b_data  = 32'h0;  b_valid  = 1'b0;
    end else begin
      acc    = ifa.i_en && (busy_left == 0);
      old_w  = mem_m[ifa.i_adr];
      merged = old_w;
      for (int b = 0; b < DB; b++)
        if (ifa.i_wen[b]) merged[8*b +: 8] = ifa.i_wdata[8*b +: 8];
      if (busy_left > 0) begin
        mem_m[DEPTH - busy_left] = 32'h0;
        busy_left--;
      end else if (acc) begin
        mem_m[ifa.i_adr] = merged;
      end
      b_valid = b1_valid;
      if (b1_valid) b_data = b1_data;
      a_valid = acc;
      if (acc) a_data = old_w;
      b1_valid = acc;
      if (acc) b1_data = merged;
    end
    @(negedge clk);
    chk("busy_rf",   32'(ifa.o_busy),   32'(busy_left > 0));
    chk("busy_wf",   32'(ifb.o_busy),   32'(busy_left > 0));
    chk("rvalid_rf", 32'(ifa.o_rvalid), 32'(a_valid));
    chk("rvalid_wf", 32'(ifb.o_rvalid), 32'(b_valid));
    chk("rdata_rf",  ifa.o_rdata,       a_data);
    chk("rdata_wf",  ifb.o_rdata,       b_data);
  endtask

  initial begin
    int          busy_cnt;
    logic [3:0]  last_adr;
    logic [3:0]  adr;

    // Power-up reset and full clear
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40 && ifa.o_busy === 1'b1; i++) begin
      busy_cnt++;
      tick();
    end
    chk("busy_len", 32'(busy_cnt), 32'd16);

    // Every word reads back as zero after the clear
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'h0, 4'(i), $urandom);
      tick();
    end
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    tick();
    tick();

    // Byte-enable merge at address 5
    drive(1'b1, 4'hF, 4'd5, 32'hA1B2C3D4);
    tick();
    drive(1'b1, 4'b0101, 4'd5, 32'h11223344);
    tick();
    drive(1'b1, 4'h0, 4'd5, 32'h0);
    tick();
    chk("merge_rf", ifa.o_rdata, 32'hA122C344);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    tick();
    chk("merge_wf", ifb.o_rdata, 32'hA122C344);

    // Read-during-write at address 7, then a plain read
    drive(1'b1, 4'hF, 4'd7, 32'hDEADBEEF);
    tick();
    chk("rdw_rf", ifa.o_rdata, 32'h00000000);
    drive(1'b1, 4'h0, 4'd7, 32'h0);
    tick();
    chk("rdw_wf", ifb.o_rdata, 32'hDEADBEEF);
    chk("rdw_next_rf", ifa.o_rdata, 32'hDEADBEEF);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    tick();
    chk("rdw_next_wf", ifb.o_rdata, 32'hDEADBEEF);

    // Output register latency and hold while idle
    drive(1'b1, 4'h0, 4'd5, 32'h0);
    tick();
    chk("lat_wf_t1", 32'(ifb.o_rvalid), 32'd0);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    tick();
    chk("lat_wf_t2", 32'(ifb.o_rvalid), 32'd1);
    chk("lat_wf_data", ifb.o_rdata, 32'hA122C344);
    repeat (4) tick();
    chk("hold_wf", ifb.o_rdata, 32'hA122C344);

    // Reset in the middle of the clear restarts it; accesses while busy are dropped
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40 && ifa.o_busy === 1'b1; i++) begin
      busy_cnt++;
      drive(1'($urandom_range(0, 1)), 4'hF, 4'($urandom), $urandom | 32'h1);
      tick();
    end
    chk("busy_len_restart", 32'(busy_cnt), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'h0, 4'(i), $urandom);
      tick();
    end

    // Random accesses with frequent back-to-back hits on the same word
    last_adr = 4'h0;
    for (int i = 0; i < 400; i++) begin
      adr = ($urandom_range(0, 2) == 0) ? last_adr : 4'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), adr, $urandom);
      last_adr = adr;
      tick();
    end
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
